// File: rtl/dco_freq_counter_if.sv
// Measurement control and result bundle for the DCO frequency counter.
// The master side drives control and the DCO pin; the slave side (the counter) returns results.
interface dco_freq_counter_if #(
   parameter int CNT_W = 16
);
   logic             ena;
   logic             dco_in;
   logic             start;
   logic             cont;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output ena, dco_in, start, cont,
      input  busy, done, count, overflow
   );

   modport slave (
      input  ena, dco_in, start, cont,
      output busy, done, count, overflow
   );
endinterface

// File: rtl/dco_freq_counter.sv
// Gated frequency counter: counts synchronized DCO rising edges over a window of
// GATE_CYCLES clk cycles, single-shot or free-running back-to-back windows.
//
// state | meaning
// IDLE  | no window open; waits for ena && start
// GATE  | window open; gate_cnt counts down, edge_cnt accumulates DCO edges
module dco_freq_counter #(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               rst_n,
   dco_freq_counter_if.slave bus
);
   localparam int               GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic {IDLE, GATE} state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic             dco_edge;
   logic             at_max;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             ovf_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.dco_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign dco_edge = s2 & ~s3;
   assign at_max   = (edge_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         gate_cnt     <= '0;
         edge_cnt     <= '0;
         ovf_int      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.count    <= '0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ena && bus.start) begin
                  state    <= GATE;
                  bus.busy <= 1'b1;
                  gate_cnt <= GATE_LOAD;
                  edge_cnt <= '0;
                  ovf_int  <= 1'b0;
               end
            end
            GATE: begin
               if (!bus.ena) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else if (gate_cnt == '0) begin
                  // final window cycle: fold this cycle's edge into the published result
                  bus.count    <= (dco_edge && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
                  bus.overflow <= ovf_int | (dco_edge & at_max);
                  bus.done     <= 1'b1;
                  gate_cnt     <= GATE_LOAD;
                  edge_cnt     <= '0;
                  ovf_int      <= 1'b0;
                  if (!bus.cont) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end else begin
                  if (dco_edge) begin
                     if (at_max) ovf_int  <= 1'b1;
                     else        edge_cnt <= edge_cnt + CNT_W'(1);
                  end
                  gate_cnt <= gate_cnt - GW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dco_freq_counter.sv
// Scoreboard bench for dco_freq_counter: two instances (100-cycle/16-bit and 64-cycle/4-bit windows)
// driven by a clk-derived DCO model; expected results are queued at start and checked on done.
`timescale 1ns/1ps
module tb_dco_freq_counter;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dco_freq_counter_if #(.CNT_W(16)) if_a ();
   dco_freq_counter_if #(.CNT_W(4))  if_b ();

   dco_freq_counter #(.GATE_CYCLES(100), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   dco_freq_counter #(.GATE_CYCLES(64),  .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   // DCO model: toggles every hp clk cycles, changing on the falling clk edge
   int   hp = 2;
   int   ph = 0;
   logic dco = 1'b0;
   always @(negedge clk) begin
      if (hp > 0) begin
         if (ph >= hp - 1) begin
            ph  = 0;
            dco = ~dco;
         end else begin
            ph = ph + 1;
         end
      end
   end
   assign if_a.dco_in = dco;
   assign if_b.dco_in = dco;

   typedef struct {
      int lo;
      int hi;
      int ovf;
      int cyc;
      int pair;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int   prev_a = 0;
   int   prev_b = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d (cyc=%0d)", name, act, lo, hi, cyc);
      end
   endtask

   task automatic score(input string tag, input exp_t e, input int cnt, input int ovf,
                        input int now, input int prev);
      chk({tag, "_count"},      cnt, e.lo,  e.hi);
      chk({tag, "_overflow"},   ovf, e.ovf, e.ovf);
      chk({tag, "_done_cycle"}, now, e.cyc, e.cyc);
      if (e.pair != 0) chk({tag, "_pair_sum"}, prev + cnt, e.pair, e.pair);
   endtask

   always @(negedge clk) begin
      if (rst_n && if_a.done) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_done actual=done required=no_done (cyc=%0d)", cyc);
         end else begin
            ea = q_a.pop_front();
            score("a", ea, int'(if_a.count), int'(if_a.overflow), cyc, prev_a);
         end
         prev_a = int'(if_a.count);
      end
   end

   always @(negedge clk) begin
      if (rst_n && if_b.done) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_done actual=done required=no_done (cyc=%0d)", cyc);
         end else begin
            eb = q_b.pop_front();
            score("b", eb, int'(if_b.count), int'(if_b.overflow), cyc, prev_b);
         end
         prev_b = int'(if_b.count);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_a(input int lo, input int hi, input int ovf, input int at, input int pair);
      exp_t e;
      e.lo = lo; e.hi = hi; e.ovf = ovf; e.cyc = at; e.pair = pair;
      q_a.push_back(e);
   endtask

   task automatic push_b(input int lo, input int hi, input int ovf, input int at);
      exp_t e;
      e.lo = lo; e.hi = hi; e.ovf = ovf; e.cyc = at; e.pair = 0;
      q_b.push_back(e);
   endtask

   // Sweep: DCO code 0x01..0x80 maps to a half-period in clk cycles; bounds are 100/(2*hp) +/- 1
   int sw_hp[8] = '{40, 32, 24, 16, 10, 6, 3, 2};
   int sw_lo[8] = '{ 1,  1,  2,  3,  4, 8, 16, 24};
   int sw_hi[8] = '{ 2,  2,  3,  4,  6, 9, 17, 26};

   int n0;
   int ok;

   initial begin
      if_a.ena = 1'b0; if_a.start = 1'b0; if_a.cont = 1'b0;
      if_b.ena = 1'b0; if_b.start = 1'b0; if_b.cont = 1'b0;
      #1 rst_n = 1'b0;
      tick(3);
      chk("rst_busy",     int'(if_a.busy),     0, 0);
      chk("rst_done",     int'(if_a.done),     0, 0);
      chk("rst_count",    int'(if_a.count),    0, 0);
      chk("rst_overflow", int'(if_a.overflow), 0, 0);
      rst_n = 1'b1;
      tick(2);
      if_a.ena = 1'b1;
      if_b.ena = 1'b1;

      // single shot, DCO period 4 cycles
      tick(20);
      n0 = cyc;
      if_a.start = 1'b1;
      push_a(25, 25, 0, n0 + 101, 0);
      tick(1);
      if_a.start = 1'b0;
      ok = 1;
      for (int i = 0; i < 100; i++) begin
         if (!if_a.busy) ok = 0;
         tick(1);
      end
      chk("ss_busy_window", ok, 1, 1);
      chk("ss_busy_after", int'(if_a.busy), 0, 0);
      tick(5);

      // abort at window cycle 50
      n0 = cyc;
      if_a.start = 1'b1;
      tick(1);
      if_a.start = 1'b0;
      tick(49);
      if_a.ena = 1'b0;
      tick(1);
      chk("abort_busy", int'(if_a.busy), 0, 0);
      tick(150);
      chk("abort_count_kept",    int'(if_a.count),    25, 25);
      chk("abort_overflow_kept", int'(if_a.overflow), 0, 0);
      if_a.ena = 1'b1;
      tick(5);

      // start held for 20 cycles does not stretch or restart the window; DCO period 6
      hp = 3;
      tick(20);
      n0 = cyc;
      if_a.start = 1'b1;
      push_a(16, 17, 0, n0 + 101, 0);
      tick(20);
      if_a.start = 1'b0;
      tick(80);
      chk("held_busy_last", int'(if_a.busy), 1, 1);
      tick(1);
      chk("held_busy_end", int'(if_a.busy), 0, 0);
      tick(5);

      // continuous mode, DCO period 8: 12/13 per window, 25 per pair
      hp = 4;
      tick(30);
      if_a.cont = 1'b1;
      n0 = cyc;
      if_a.start = 1'b1;
      for (int k = 1; k <= 4; k++) push_a(12, 13, 0, n0 + 1 + 100 * k, (k > 1) ? 25 : 0);
      tick(1);
      if_a.start = 1'b0;
      ok = 1;
      for (int i = 0; i < 400; i++) begin
         if (!if_a.busy) ok = 0;
         if (i == 349) if_a.cont = 1'b0;
         tick(1);
      end
      chk("cont_busy_held", ok, 1, 1);
      chk("cont_busy_end", int'(if_a.busy), 0, 0);
      tick(5);

      // saturation on the 4-bit counter, then a clean window
      hp = 2;
      tick(20);
      n0 = cyc;
      if_b.start = 1'b1;
      push_b(15, 15, 1, n0 + 65);
      tick(1);
      if_b.start = 1'b0;
      tick(70);
      hp = 4;
      tick(20);
      n0 = cyc;
      if_b.start = 1'b1;
      push_b(8, 8, 0, n0 + 65);
      tick(1);
      if_b.start = 1'b0;
      tick(70);

      // reset mid-window with the DCO running
      hp = 2;
      tick(10);
      if_a.start = 1'b1;
      tick(1);
      if_a.start = 1'b0;
      tick(30);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy",       int'(if_a.busy),     0, 0);
      chk("midrst_done",       int'(if_a.done),     0, 0);
      chk("midrst_count",      int'(if_a.count),    0, 0);
      chk("midrst_overflow",   int'(if_a.overflow), 0, 0);
      chk("midrst_b_count",    int'(if_b.count),    0, 0);
      chk("midrst_b_overflow", int'(if_b.overflow), 0, 0);
      q_a.delete();
      tick(2);
      rst_n = 1'b1;
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         if (if_a.busy) ok = 0;
         tick(1);
      end
      chk("postrst_idle", ok, 1, 1);

      // DCO code sweep
      for (int c = 0; c < 8; c++) begin
         hp = sw_hp[c];
         tick(100);
         n0 = cyc;
         if_a.start = 1'b1;
         push_a(sw_lo[c], sw_hi[c], 0, n0 + 101, 0);
         tick(1);
         if_a.start = 1'b0;
         tick(110);
      end

      tick(5);
      chk("a_pending_results", q_a.size(), 0, 0);
      chk("b_pending_results", q_b.size(), 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dco_freq_counter.md
# dco_freq_counter

Gated frequency counter that measures the DCO output against the system clock. It counts rising edges of the asynchronous `dco_in` over a programmable window of `GATE_CYCLES` clock cycles and reports the edge count, so the code-to-frequency transfer of the DCO can be characterised on-chip. It sits directly downstream of the DCO, consuming its output, and can run single-shot or free-running.

## Interface
- `GATE_CYCLES`, default 1000: measurement window length in `clk` cycles. Legal range is 2 to 2^24.
- `CNT_W`, default 16: width of the edge counter and of the `count` result.
- `clk`  in  1: system clock; all state is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: block enable; low aborts any measurement.
- `dco_in`  in  1: DCO output, asynchronous to `clk`.
- `start`  in  1: level-sampled request for one measurement.
- `cont`  in  1: continuous mode; back-to-back windows with no dead cycles.
- `busy`  out  1: high while a gate window is open.
- `done`  out  1: one-cycle pulse when a new result has been latched.
- `count`  out  CNT_W: edge count of the last completed window.
- `overflow`  out  1: the last completed window saturated the counter.

## Operation
- **Synchronizer:** `dco_in` passes through two flops (s1, s2), then a history flop s3.
  - Edge pulse: `edge = s2 & ~s3`.
  - All three flops reset to 0.
  - Exact counting is guaranteed when each high phase and each low phase of `dco_in` lasts at least 2 `clk` periods.
- **States:** IDLE and GATE.
  - Internal registers: `gate_cnt` (down-counter) and `edge_cnt` (CNT_W bits, saturating), plus a sticky `ovf_int`.
- **IDLE:**
  - If `ena && start`: go to GATE, load `gate_cnt = GATE_CYCLES-1`, clear `edge_cnt` and `ovf_int`.
  - Otherwise stay in IDLE.
- **GATE, every cycle:**
  - If `edge` is high: increment `edge_cnt` if it is below 2^CNT_W-1; otherwise hold it and set `ovf_int`.
  - Decrement `gate_cnt`.
- **GATE, final cycle (`gate_cnt == 0`):**
  - `count` takes `edge_cnt` plus this cycle's `edge`, saturated at 2^CNT_W-1.
  - `overflow` takes `ovf_int` OR-ed with this cycle's saturation.
  - `done` is 1 on the next cycle.
  - If `cont && ena`: stay in GATE, reload `gate_cnt`, clear `edge_cnt` and `ovf_int`.
  - Otherwise go to IDLE.
- **Window coverage:** each window samples `edge` on exactly `GATE_CYCLES` consecutive cycles. In continuous mode, consecutive windows tile with no gap and no overlap.
- **`ena` low in GATE:** go to IDLE next cycle. No `done` pulse; `count` and `overflow` keep their previous values.
- **`start` while busy:** ignored. `start` still high when returning to IDLE starts a new window on the following cycle.
- **`cont` sampling:** `cont` is sampled only on the final GATE cycle. Dropping it mid-window lets the current window complete normally.
- **Async reset:**
  - State goes to IDLE.
  - `busy`, `done`, `count`, `overflow` go to 0.
  - `gate_cnt`, `edge_cnt`, `ovf_int` go to 0; synchronizer flops go to 0.
  - Reset mid-window discards the window.

## Timing
- **Outputs:** all registered, no combinational input-to-output paths. `busy` equals (state == GATE).
- **Start:** `start` sampled high at edge T puts `busy` high from T+1. The window is the `edge` samples at edges T+1 .. T+GATE_CYCLES.
- **Done:** `done` and the new `count`/`overflow` appear at T+GATE_CYCLES+1, in the same cycle.
  - Single-shot: `busy` is already low in that cycle.
  - Continuous: `busy` stays high.
- **Pin-to-count latency:** a `dco_in` rising edge is counted at the third `clk` edge after it. An edge arriving within 3 cycles of a window boundary is credited to the next window.
- **Continuous mode:** `done` pulses every `GATE_CYCLES` cycles exactly.

## Test plan
- **Reset values:** Assert `rst_n`=0 mid-window with the DCO toggling. All outputs are 0 immediately. After release, `busy` stays 0 until `start`.
- **Single-shot count:** `GATE_CYCLES`=100; `dco_in` toggles every 2 `clk` cycles from well before `start`; one-cycle `start` at T. `busy` is high over T+1..T+100; `done` pulses at T+101; `count`=25; `overflow`=0.
- **Continuous mode:** `GATE_CYCLES`=100, `cont`=1, `dco_in` period 8 cycles. `done` pulses every 100 cycles; the window counts alternate 12/13 to give exactly 25 per 200 cycles; `busy` never drops. Then `cont`=0: one more `done`, then `busy`=0.
- **Saturation:** `CNT_W`=4, `GATE_CYCLES`=64, `dco_in` period 4 cycles. `count`=15, `overflow`=1. A following window at period 8 gives `count`=8, `overflow`=0.
- **Abort:** drop `ena` at window cycle 50. `busy`=0 next cycle, no `done`, `count` keeps its prior value. `start` while busy has no effect on window length.
- **Code sweep:** drive the DCO with codes 0x01, 0x02, 0x04 … 0x80 and one measurement per code. Each `count` matches `GATE_CYCLES`·f_dco/f_clk to within ±1.
